tmr_bank: RTL and testbench

- Parametrised multi-channel timer; next generation of the single-channel reload timer.
- Each channel has its own reload value, prescaler, one-shot or auto-reload mode, interrupt enable, and a write-1-to-clear pending flag.
- Sits on the CPU data-bus peripheral decode. Drives per-channel and combined interrupt lines to the interrupt controller.

---
 rtl/tmr_pkg.sv | 14 +
 rtl/tmr_chan.sv | 108 ++++++++++
 rtl/tmr_bank.sv | 67 ++++++
 tb/tb_tmr_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared register map and CTRL/STAT bit positions for the multi-channel timer bank.
package tmr_pkg;
    localparam logic [1:0] REG_LOAD  = 2'd0;
    localparam logic [1:0] REG_COUNT = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_STAT  = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AR      = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PRE_LSB = 8;

    localparam int STAT_PEND = 0;
endpackage

// File: rtl/tmr_chan.sv
// One timer channel: prescaler, down-counter, one-shot/auto-reload, W1C pending flag.
// Register writes take effect on the next edge; irq is combinational from pend & ie.
module tmr_chan
    import tmr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_load,
    input  logic             wr_ctrl,
    input  logic             wr_stat,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_rd,
    output logic [WIDTH-1:0] count_rd,
    output logic [WIDTH-1:0] ctrl_rd,
    output logic [WIDTH-1:0] stat_rd,
    output logic             irq
);
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] count_q;
    logic             en_q;
    logic             ar_q;
    logic             ie_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pcnt_q;
    logic             pend_q;

    logic             tick;
    logic             expire;
    logic [PRE_W-1:0] wpre;

    assign wpre   = wdata[CTRL_PRE_LSB +: PRE_W];
    assign tick   = en_q && (pcnt_q == pre_q);
    assign expire = tick && (count_q == '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pcnt_q <= '0;
        end else if (wr_load || (wr_ctrl && (wpre != pre_q))) begin
            pcnt_q <= '0;
        end else if (en_q) begin
            pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
        end
    end

    // LOAD write overrides a same-cycle decrement or reload.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            load_q  <= '0;
            count_q <= '0;
        end else if (wr_load) begin
            load_q  <= wdata;
            count_q <= wdata;
        end else if (tick) begin
            if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end else if (ar_q) begin
                count_q <= load_q;
            end
        end
    end

    // One-shot expiry clearing en wins over a software write of en.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            en_q  <= 1'b0;
            ar_q  <= 1'b0;
            ie_q  <= 1'b0;
            pre_q <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q  <= wdata[CTRL_EN];
                ar_q  <= wdata[CTRL_AR];
                ie_q  <= wdata[CTRL_IE];
                pre_q <= wpre;
            end
            if (expire && !ar_q) begin
                en_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pend_q <= 1'b0;
        end else if (expire) begin
            pend_q <= 1'b1;
        end else if (wr_stat && wdata[STAT_PEND]) begin
            pend_q <= 1'b0;
        end
    end

    always_comb begin
        ctrl_rd                         = '0;
        ctrl_rd[CTRL_EN]                = en_q;
        ctrl_rd[CTRL_AR]                = ar_q;
        ctrl_rd[CTRL_IE]                = ie_q;
        ctrl_rd[CTRL_PRE_LSB +: PRE_W]  = pre_q;
        stat_rd                         = '0;
        stat_rd[STAT_PEND]              = pend_q;
    end

    assign load_rd  = load_q;
    assign count_rd = count_q;
    assign irq      = pend_q && ie_q;
endmodule

// File: rtl/tmr_bank.sv
// NCH independent timer channels behind a {channel, reg} register decode.
// Writes land on the next edge; rdata and irqs are combinational, no stall path.
module tmr_bank
    import tmr_pkg::*;
#(
    parameter int CH_AW = 2,
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [CH_AW+1:0]     addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic [(2**CH_AW)-1:0] irq_o,
    output logic                 irq
);
    localparam int NCH = 2 ** CH_AW;

    logic [CH_AW-1:0] ch_sel;
    logic [1:0]       reg_sel;

    logic [WIDTH-1:0] load_a  [NCH];
    logic [WIDTH-1:0] count_a [NCH];
    logic [WIDTH-1:0] ctrl_a  [NCH];
    logic [WIDTH-1:0] stat_a  [NCH];

    assign ch_sel  = addr[CH_AW+1:2];
    assign reg_sel = addr[1:0];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        localparam logic [CH_AW-1:0] IDX = CH_AW'(i);
        logic hit;
        assign hit = wr_en && (ch_sel == IDX);

        tmr_chan #(
            .WIDTH (WIDTH),
            .PRE_W (PRE_W)
        ) u_chan (
            .clk      (clk),
            .clr      (clr),
            .wr_load  (hit && (reg_sel == REG_LOAD)),
            .wr_ctrl  (hit && (reg_sel == REG_CTRL)),
            .wr_stat  (hit && (reg_sel == REG_STAT)),
            .wdata    (wdata),
            .load_rd  (load_a[i]),
            .count_rd (count_a[i]),
            .ctrl_rd  (ctrl_a[i]),
            .stat_rd  (stat_a[i]),
            .irq      (irq_o[i])
        );
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_LOAD:  rdata = load_a[ch_sel];
            REG_COUNT: rdata = count_a[ch_sel];
            REG_CTRL:  rdata = ctrl_a[ch_sel];
            REG_STAT:  rdata = stat_a[ch_sel];
            default:   rdata = '0;
        endcase
    end

    assign irq = |irq_o;
endmodule

// File: tb/tb_tmr_bank.sv
`timescale 1ns/1ps
module tb_tmr_bank;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  irq_o;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

    // Reference state: registers as software sees them, plus prescaler phase.
    logic [31:0] m_load  [4];
    logic [31:0] m_count [4];
    logic [31:0] m_ctrl  [4];
    logic        m_pend  [4];
    int          m_phase [4];

    always #5 clk = ~clk;

    tmr_bank #(.CH_AW(2), .WIDTH(32), .PRE_W(8)) dut (
        .clk   (clk),
        .clr   (clr),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq_o (irq_o),
        .irq   (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_load[c] = 0; m_count[c] = 0; m_ctrl[c] = 0; m_pend[c] = 0; m_phase[c] = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        int c = a / 4;
        case (a % 4)
            0: return m_load[c];
            1: return m_count[c];
            2: return m_ctrl[c];
            default: return {31'd0, m_pend[c]};
        endcase
    endfunction

    // One clock of behaviour, given the write presented during that cycle.
    task automatic model_clock(input bit we, input int a, input logic [31:0] d);
        for (int c = 0; c < 4; c++) begin
            bit  hit   = we && (a / 4 == c);
            int  r     = a % 4;
            bit  en    = m_ctrl[c][0];
            bit  ar    = m_ctrl[c][1];
            int  pre   = int'(m_ctrl[c][15:8]);
            bit  tk    = en && (m_phase[c] == pre);
            bit  fire  = tk && (m_count[c] == 0);
            int  nphase = m_phase[c];
            logic [31:0] ncount = m_count[c];
            logic [31:0] nctrl  = m_ctrl[c];
            bit  npend = m_pend[c];

            if (en) nphase = tk ? 0 : m_phase[c] + 1;
            if (tk) ncount = (m_count[c] != 0) ? m_count[c] - 1 : (ar ? m_load[c] : 32'd0);
            if (hit && r == 2) begin
                nctrl = d & CTRL_MASK;
                if (int'(d[15:8]) != pre) nphase = 0;
            end
            if (fire && !ar) nctrl[0] = 1'b0;
            if (hit && r == 0) begin
                m_load[c] = d;
                ncount    = d;
                nphase    = 0;
            end
            if (hit && r == 3 && d[0]) npend = 1'b0;
            if (fire) npend = 1'b1;

            m_phase[c] = nphase;
            m_count[c] = ncount;
            m_ctrl[c]  = nctrl;
            m_pend[c]  = npend;
        end
    endtask

    task automatic check_all();
        logic [3:0] ei;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #0.1;
            chk($sformatf("rd[%0d]", a), rdata, model_read(a));
        end
        for (int c = 0; c < 4; c++) ei[c] = m_pend[c] && m_ctrl[c][2];
        chk("irq_o", {28'd0, irq_o}, {28'd0, ei});
        chk("irq", {31'd0, irq}, {31'd0, |ei});
    endtask

    // Entered between edges; leaves inputs idle and checks every register.
    task automatic step(input bit we, input int a, input logic [31:0] d);
        wr_en = we; addr = 4'(a); wdata = d;
        @(posedge clk);
        model_clock(we, a, d);
        @(negedge clk);
        wr_en = 1'b0;
        check_all();
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        step(1'b1, ch * 4 + r, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 32'd0);
    endtask

    int pend_rises;
    int cnt_changes;
    logic [31:0] prev_cnt;

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        clr = 1'b0;
        idle(2);

        // Ch0 auto-reload, period 4.
        wr(0, 0, 32'd3);
        wr(0, 2, 32'h7);
        pend_rises = 0;
        for (int i = 0; i < 12; i++) begin
            wr(0, 3, 32'd1);
            if (m_pend[0]) pend_rises++;
        end
        chk("ch0_expiries", pend_rises, 3);

        // Ch1 prescaled: COUNT moves every 2nd cycle.
        wr(1, 0, 32'd2);
        wr(1, 2, 32'h107);
        cnt_changes = 0;
        prev_cnt = m_count[1];
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (m_count[1] != prev_cnt) cnt_changes++;
            prev_cnt = m_count[1];
        end
        chk("ch1_changes", cnt_changes, 6);

        // Ch2 one-shot.
        wr(2, 0, 32'd5);
        wr(2, 2, 32'h5);
        idle(6);
        addr = 4'(2 * 4 + 2); #0.1;
        chk("ch2_ctrl_oneshot", rdata, 32'h4);
        addr = 4'(2 * 4 + 3); #0.1;
        chk("ch2_pend", rdata, 32'h1);
        wr(2, 3, 32'd1);
        idle(50);
        addr = 4'(2 * 4 + 3); #0.1;
        chk("ch2_no_reexpire", rdata, 32'h0);

        // W1C race on ch0 expiring every cycle, then clear while stopped.
        wr(0, 0, 32'd0);
        wr(0, 2, 32'h7);
        idle(1);
        wr(0, 3, 32'd1);
        addr = 4'(3); #0.1;
        chk("w1c_race", rdata, 32'h1);
        wr(0, 2, 32'h6);
        wr(0, 3, 32'd1);
        addr = 4'(3); #0.1;
        chk("w1c_clear", rdata, 32'h0);

        // ie masking on ch1.
        wr(1, 2, 32'h103);
        idle(8);
        wr(1, 2, 32'h100);
        chk("ie_mask", {31'd0, irq_o[1]}, 32'd0);
        wr(1, 2, 32'h104);
        chk("ie_unmask", {31'd0, irq_o[1]}, {31'd0, m_pend[1]});
        wr(1, 3, 32'd1);

        // Randomised traffic across all channels.
        for (int i = 0; i < 600; i++) begin
            int ch = $urandom_range(0, 3);
            int r  = $urandom_range(0, 3);
            logic [31:0] d;
            case (r)
                0: d = $urandom_range(0, 9);
                2: d = {16'd0, 6'd0, 2'($urandom_range(0, 3)), 5'd0, 3'($urandom)} | 32'h1;
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 9) < 3) step(1'b1, ch * 4 + r, d);
            else step(1'b0, 0, 32'd0);
        end

        // Async reset mid-count on ch3.
        wr(3, 0, 32'h100);
        wr(3, 2, 32'h7);
        idle(20);
        #1 clr = 1'b1;
        #0.5;
        model_reset();
        check_all();
        @(negedge clk);
        clr = 1'b0;
        idle(10);
        chk("post_reset_cnt3", m_count[3], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
